agp32_mem_ctrl: RTL

Memory-side model/controller directly downstream of the processor wrapper. Consumes the wrapper's word-aligned inst_addr/data_addr, command, write data and strobes. Returns inst_rdata, data_rdata, ready, hit, error, mem_start_ready and interrupt_ack over a single-word internal RAM with configurable wait states and a one-entry instruction line buffer. Used as the FPGA/simulation memory subsystem behind the pipeline.

---
 rtl/agp32_mem_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/agp32_mem_ctrl.sv
// agp32_mem_ctrl: word RAM behind the processor wrapper with miss wait states,
// a one-entry instruction line buffer and a delayed interrupt acknowledge.
module agp32_mem_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int LATENCY     = 4,
  parameter int INIT_CYCLES = 16,
  parameter int IRQ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  command,
  input  logic [31:0] inst_addr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  input  logic        interrupt_req,
  output logic        ready,
  output logic        hit,
  output logic [1:0]  error,
  output logic        mem_start_ready,
  output logic [31:0] inst_rdata,
  output logic [31:0] data_rdata,
  output logic        interrupt_ack
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int ICW   = $clog2(INIT_CYCLES + 1);
  localparam int WCW   = $clog2(LATENCY + 1);
  localparam int QCW   = $clog2(IRQ_LATENCY + 1);

  localparam logic [2:0] CMD_NOP         = 3'd0;
  localparam logic [2:0] CMD_FETCH       = 3'd1;
  localparam logic [2:0] CMD_FETCH_LOAD  = 3'd2;
  localparam logic [2:0] CMD_FETCH_STORE = 3'd3;
  localparam logic [2:0] CMD_LOAD        = 3'd4;
  localparam logic [2:0] CMD_STORE       = 3'd5;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  state_t          state_r, state_next_s;
  logic [ICW-1:0]  init_cnt_r, init_cnt_next_s;
  logic [WCW-1:0]  wait_cnt_r, wait_cnt_next_s;
  logic            accept_s, complete_s, init_done_s;
  logic            hit_now_s, illegal_now_s;

  logic [2:0]      cmd_r;
  logic [29:0]     inst_word_r, data_word_r;
  logic [31:0]     wdata_r;
  logic [3:0]      wstrb_r;
  logic            hit_pend_r;

  logic            lb_valid_r, lb_valid_next_s;
  logic [29:0]     lb_tag_r, lb_tag_next_s;
  logic [31:0]     lb_data_r, lb_data_next_s;

  logic [31:0]     mem_r [DEPTH];

  logic            is_fetch_s, fetches_s, loads_s, stores_s, illegal_s;
  logic            inst_oor_s, data_oor_s, store_en_s;
  logic [31:0]     ram_inst_s, ram_data_s, inst_word_s, data_word_s, store_word_s;
  logic [1:0]      err_s;

  logic            ready_r, hit_r, msr_r, ack_r;
  logic [1:0]      error_r;
  logic [31:0]     inst_rdata_r, data_rdata_r;

  logic            irq_d_r, irq_pend_r, irq_pend_next_s, ack_next_s, irq_rise_s;
  logic [QCW-1:0]  irq_cnt_r, irq_cnt_next_s;

  // Inputs are word aligned; the byte-offset bits carry no information.
  logic            unused_addr_bits_s;
  assign unused_addr_bits_s = ^{inst_addr[1:0], data_addr[1:0]};

  assign hit_now_s     = (command == CMD_FETCH) && lb_valid_r && (inst_addr[31:2] == lb_tag_r);
  assign illegal_now_s = command[2] & command[1];
  assign init_done_s   = (state_r == ST_INIT) && (init_cnt_r == ICW'(INIT_CYCLES - 1));

  // Next-state logic for the INIT/IDLE/BUSY controller.
  always_comb begin
    state_next_s    = state_r;
    init_cnt_next_s = init_cnt_r;
    wait_cnt_next_s = wait_cnt_r;
    accept_s        = 1'b0;
    complete_s      = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (init_done_s) begin
          state_next_s    = ST_IDLE;
          init_cnt_next_s = '0;
        end else begin
          init_cnt_next_s = init_cnt_r + ICW'(1);
        end
      end
      ST_IDLE: begin
        if (command != CMD_NOP) begin
          accept_s     = 1'b1;
          state_next_s = ST_BUSY;
          if (hit_now_s || illegal_now_s) begin
            wait_cnt_next_s = WCW'(1);
          end else begin
            wait_cnt_next_s = WCW'(LATENCY);
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (wait_cnt_r == WCW'(1)) begin
          complete_s   = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          wait_cnt_next_s = wait_cnt_r - WCW'(1);
        end
      end
      default: begin
        state_next_s = ST_INIT;
      end
    endcase
  end

  // Controller state and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_INIT;
      init_cnt_r <= '0;
      wait_cnt_r <= '0;
    end else begin
      state_r    <= state_next_s;
      init_cnt_r <= init_cnt_next_s;
      wait_cnt_r <= wait_cnt_next_s;
    end
  end

  // Request capture when a command is accepted in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_r       <= 3'd0;
      inst_word_r <= 30'd0;
      data_word_r <= 30'd0;
      wdata_r     <= 32'd0;
      wstrb_r     <= 4'd0;
      hit_pend_r  <= 1'b0;
    end else if (accept_s) begin
      cmd_r       <= command;
      inst_word_r <= inst_addr[31:2];
      data_word_r <= data_addr[31:2];
      wdata_r     <= data_wdata;
      wstrb_r     <= data_wstrb;
      hit_pend_r  <= hit_now_s;
    end
  end

  assign is_fetch_s = (cmd_r == CMD_FETCH);
  assign fetches_s  = (cmd_r == CMD_FETCH) || (cmd_r == CMD_FETCH_LOAD) || (cmd_r == CMD_FETCH_STORE);
  assign loads_s    = (cmd_r == CMD_FETCH_LOAD) || (cmd_r == CMD_LOAD);
  assign stores_s   = (cmd_r == CMD_FETCH_STORE) || (cmd_r == CMD_STORE);
  assign illegal_s  = cmd_r[2] & cmd_r[1];

  assign inst_oor_s = |inst_word_r[29:ADDR_W];
  assign data_oor_s = |data_word_r[29:ADDR_W];

  // Reads see the RAM as it was before this request's store lands.
  assign ram_inst_s   = mem_r[inst_word_r[ADDR_W-1:0]];
  assign ram_data_s   = mem_r[data_word_r[ADDR_W-1:0]];
  assign inst_word_s  = inst_oor_s ? 32'd0 : (hit_pend_r ? lb_data_r : ram_inst_s);
  assign data_word_s  = data_oor_s ? 32'd0 : ram_data_s;
  assign store_word_s = merge_bytes(ram_data_s, wdata_r, wstrb_r);
  assign store_en_s   = complete_s && stores_s && !data_oor_s;

  // Completion status: illegal command outranks an out-of-range address.
  always_comb begin
    err_s = 2'b00;
    if (illegal_s) begin
      err_s = 2'b10;
    end else if ((fetches_s && inst_oor_s) || ((loads_s || stores_s) && data_oor_s)) begin
      err_s = 2'b01;
    end else begin
      err_s = 2'b00;
    end
  end

  // Line buffer refill on FETCH and store snooping to keep it coherent.
  always_comb begin
    lb_valid_next_s = lb_valid_r;
    lb_tag_next_s   = lb_tag_r;
    lb_data_next_s  = lb_data_r;
    if (complete_s && is_fetch_s) begin
      lb_valid_next_s = 1'b1;
      lb_tag_next_s   = inst_word_r;
      lb_data_next_s  = inst_word_s;
    end else begin
      lb_valid_next_s = lb_valid_r;
    end
    if (store_en_s && lb_valid_next_s && (data_word_r == lb_tag_next_s)) begin
      lb_data_next_s = merge_bytes(lb_data_next_s, wdata_r, wstrb_r);
    end else begin
      lb_data_next_s = lb_data_next_s;
    end
  end

  // Line buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_valid_r <= 1'b0;
      lb_tag_r   <= 30'd0;
      lb_data_r  <= 32'd0;
    end else begin
      lb_valid_r <= lb_valid_next_s;
      lb_tag_r   <= lb_tag_next_s;
      lb_data_r  <= lb_data_next_s;
    end
  end

  // RAM array; contents survive reset.
  always_ff @(posedge clk) begin
    if (store_en_s) begin
      mem_r[data_word_r[ADDR_W-1:0]] <= store_word_s;
    end
  end

  // Registered handshake and read-data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r      <= 1'b0;
      msr_r        <= 1'b0;
      hit_r        <= 1'b0;
      error_r      <= 2'b00;
      inst_rdata_r <= 32'd0;
      data_rdata_r <= 32'd0;
    end else begin
      ready_r <= (state_next_s == ST_IDLE);
      if (init_done_s) begin
        msr_r <= 1'b1;
      end
      if (complete_s) begin
        hit_r   <= hit_pend_r;
        error_r <= err_s;
        if (fetches_s) begin
          inst_rdata_r <= inst_word_s;
        end
        if (loads_s) begin
          data_rdata_r <= data_word_s;
        end
      end
    end
  end

  assign irq_rise_s = interrupt_req & ~irq_d_r;

  // Interrupt delay: a new request edge (re)starts the countdown to the ack pulse.
  always_comb begin
    irq_pend_next_s = irq_pend_r;
    irq_cnt_next_s  = irq_cnt_r;
    ack_next_s      = 1'b0;
    if (irq_rise_s) begin
      irq_pend_next_s = 1'b1;
      irq_cnt_next_s  = QCW'(IRQ_LATENCY);
    end else if (irq_pend_r) begin
      if (irq_cnt_r == QCW'(1)) begin
        ack_next_s      = 1'b1;
        irq_pend_next_s = 1'b0;
      end else begin
        irq_cnt_next_s = irq_cnt_r - QCW'(1);
      end
    end else begin
      irq_pend_next_s = 1'b0;
    end
  end

  // Interrupt registers, independent of the memory controller state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_d_r    <= 1'b0;
      irq_pend_r <= 1'b0;
      irq_cnt_r  <= '0;
      ack_r      <= 1'b0;
    end else begin
      irq_d_r    <= interrupt_req;
      irq_pend_r <= irq_pend_next_s;
      irq_cnt_r  <= irq_cnt_next_s;
      ack_r      <= ack_next_s;
    end
  end

  assign ready           = ready_r;
  assign hit             = hit_r;
  assign error           = error_r;
  assign mem_start_ready = msr_r;
  assign inst_rdata      = inst_rdata_r;
  assign data_rdata      = data_rdata_r;
  assign interrupt_ack   = ack_r;

endmodule
